conv_core: RTL

- Sequential convolution engine that produces the eight 8-bit result values consumed by the seven-segment display stage.
- Holds a 4x4 input image, a 3x3 kernel (K9) and a 2x2 kernel (K4), all loaded through a write port.
- On `start`, one MAC per cycle computes:
  - c9_*: 3x3 kernel, stride 1 → 2x2 results.
  - c4_*: 2x2 kernel, stride 2 → 2x2 results.
- Results are saturated to 8 bits, registered, and held stable for the display.

---
 rtl/conv_pkg.sv | 45 ++++
 rtl/conv_mac.sv | 40 ++++
 rtl/conv_core.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine: FSM states,
// operand dimensions, write-target codes and kernel tap decoding.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_C9   = 2'd1,
        ST_C4   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int IMG_N   = 4;
    localparam int K9_N    = 3;
    localparam int K4_N    = 2;
    localparam int N_OUT   = 4;
    localparam int IMG_PIX = IMG_N * IMG_N;
    localparam int K9_TAPS = K9_N * K9_N;
    localparam int K4_TAPS = K4_N * K4_N;

    localparam logic [1:0] SEL_IMG = 2'd0;
    localparam logic [1:0] SEL_K9  = 2'd1;
    localparam logic [1:0] SEL_K4  = 2'd2;

    typedef struct packed {
        logic [1:0] kr;
        logic [1:0] kc;
    } tap_rc_t;

    // Row/column of a 3x3 kernel tap (t/3, t%3) without a divider.
    function automatic tap_rc_t k9_tap_rc(input logic [3:0] t);
        tap_rc_t rc;
        if (t >= 4'd6) begin
            rc.kr = 2'd2;
            rc.kc = 2'(t - 4'd6);
        end else if (t >= 4'd3) begin
            rc.kr = 2'd1;
            rc.kc = 2'(t - 4'd3);
        end else begin
            rc.kr = 2'd0;
            rc.kc = t[1:0];
        end
        return rc;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate slice: combinational product and running sum, with the
// accumulator cleared after the last tap and the result saturated to OW bits.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DW   = 4,
    parameter int OW   = 8,
    parameter int ACCW = 12   // must be at least 2*DW+4 so nine taps never wrap
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          last,
    input  logic [DW-1:0] pix,
    input  logic [DW-1:0] wgt,
    output logic [OW-1:0] result
);

    localparam logic [ACCW-1:0] SAT_MAX = ACCW'((1 << OW) - 1);

    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] sum;

    assign prod   = {{DW{1'b0}}, pix} * {{DW{1'b0}}, wgt};
    assign sum    = acc + ACCW'(prod);
    assign result = (sum > SAT_MAX) ? {OW{1'b1}} : sum[OW-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= last ? '0 : sum;
        end
    end

endmodule

// File: rtl/conv_core.sv
// Sequential convolution engine: 3x3/stride-1 and 2x2/stride-2 passes over a
// 4x4 image, one MAC per cycle, eight saturated results held for the display.
module conv_core
    import conv_pkg::*;
#(
    parameter int DW   = 4,
    parameter int OW   = 8,
    parameter int ACCW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [OW-1:0] c9_11,
    output logic [OW-1:0] c9_12,
    output logic [OW-1:0] c9_21,
    output logic [OW-1:0] c9_22,
    output logic [OW-1:0] c4_11,
    output logic [OW-1:0] c4_12,
    output logic [OW-1:0] c4_21,
    output logic [OW-1:0] c4_22
);

    state_t state_q, state_d;

    logic [DW-1:0] img [0:IMG_PIX-1];
    logic [DW-1:0] k9  [0:K9_TAPS-1];
    logic [DW-1:0] k4  [0:K4_TAPS-1];
    logic [OW-1:0] c9_q [0:N_OUT-1];
    logic [OW-1:0] c4_q [0:N_OUT-1];

    logic [1:0]    out_idx;
    logic [3:0]    tap;
    logic          last_tap, last_out, mac_en, mac_clr;
    logic [1:0]    row, col;
    logic [DW-1:0] pix, wgt;
    logic [OW-1:0] mac_result;
    tap_rc_t       rc9;

    // NOTE: the operand memories carry a reset because a cleared image and
    // kernels are part of the defined post-reset state, not just the control.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IMG_PIX; i++) img[i] <= '0;
            for (int i = 0; i < K9_TAPS; i++) k9[i]  <= '0;
            for (int i = 0; i < K4_TAPS; i++) k4[i]  <= '0;
        end else if (wr_en && state_q == ST_IDLE) begin
            unique case (wr_sel)
                SEL_IMG: img[wr_addr] <= wr_data;
                SEL_K9:  if (wr_addr < 4'(K9_TAPS)) k9[wr_addr] <= wr_data;
                SEL_K4:  if (wr_addr < 4'(K4_TAPS)) k4[wr_addr[1:0]] <= wr_data;
                default: ;
            endcase
        end
    end

    assign mac_en   = (state_q == ST_C9) || (state_q == ST_C4);
    assign mac_clr  = (state_q == ST_IDLE) && start;
    assign last_tap = ((state_q == ST_C9) && (tap == 4'(K9_TAPS - 1))) ||
                      ((state_q == ST_C4) && (tap == 4'(K4_TAPS - 1)));
    assign last_out = (out_idx == 2'(N_OUT - 1));

    // Image coordinate = output origin + kernel offset; stride 2 doubles the origin.
    always_comb begin
        rc9 = k9_tap_rc(tap);
        row = '0;
        col = '0;
        wgt = '0;
        if (state_q == ST_C4) begin
            row = {out_idx[1], tap[1]};
            col = {out_idx[0], tap[0]};
            wgt = k4[tap[1:0]];
        end else begin
            row = {1'b0, out_idx[1]} + rc9.kr;
            col = {1'b0, out_idx[0]} + rc9.kc;
            wgt = k9[tap];
        end
        pix = img[{row, col}];
    end

    conv_mac #(
        .DW   (DW),
        .OW   (OW),
        .ACCW (ACCW)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (mac_clr),
        .en     (mac_en),
        .last   (last_tap),
        .pix    (pix),
        .wgt    (wgt),
        .result (mac_result)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_C9;
            ST_C9:   if (last_tap && last_out) state_d = ST_C4;
            ST_C4:   if (last_tap && last_out) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_idx <= '0;
            tap     <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                c9_q[i] <= '0;
                c4_q[i] <= '0;
            end
        end else if (mac_clr) begin
            out_idx <= '0;
            tap     <= '0;
        end else if (mac_en) begin
            if (last_tap) begin
                tap     <= '0;
                out_idx <= out_idx + 2'd1;
                if (state_q == ST_C9) c9_q[out_idx] <= mac_result;
                else                  c4_q[out_idx] <= mac_result;
            end else begin
                tap <= tap + 4'd1;
            end
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);

    assign c9_11 = c9_q[0];
    assign c9_12 = c9_q[1];
    assign c9_21 = c9_q[2];
    assign c9_22 = c9_q[3];
    assign c4_11 = c4_q[0];
    assign c4_12 = c4_q[1];
    assign c4_21 = c4_q[2];
    assign c4_22 = c4_q[3];

endmodule
